reaction_history_regfile: RTL
=============================

Name: reaction_history_regfile

Overview:
- Eight-entry, 13-bit register bank holding the last eight reaction-time results, in millisecond ticks.
- Sits directly upstream of the 8:1 word selector. Drives all eight stored words in parallel; the selector picks one for display.
- Writes go to a circular slot. The oldest result is overwritten once the bank is full.
- Also tracks the valid count and the best (minimum) stored time with its slot index, for the "best score" display.

Parameters:
- WIDTH, 13, bits per stored reaction time.
- DEPTH, 8, entry count. Fixed to match the 8-input selector; other values are unsupported.
- EMPTY_BEST, 13'h1FFF, value driven on Best when no entry is valid.

Ports:
- Clock  in  1  rising-edge system clock.
- Reset  in  1  asynchronous, active-high reset.
- WrEn  in  1  write strobe; one result is stored per cycle in which it is high.
- WrData  in  13  reaction time to store.
- Clear  in  1  synchronous clear of the whole history (new game session).
- W0..W7  out  13 each  stored entries, registered; slot n on Wn.
- WrPtr  out  3  slot the next write will use.
- Count  out  4  number of valid entries, 0..8.
- Full  out  1  high when Count == 8.
- Best  out  13  minimum over valid entries.
- BestIdx  out  3  slot holding Best.

Behaviour:
- Reset (async, takes effect immediately, independent of Clock):
  - W0..W7 = 0, WrPtr = 0, Count = 0, Full = 0.
  - Best = EMPTY_BEST, BestIdx = 0.
  - Valid mask = 0.
- Write (WrEn=1, Clear=0) at a rising edge:
  - entry[WrPtr] <= WrData; valid[WrPtr] <= 1.
  - WrPtr <= WrPtr+1, mod 8 (7 wraps to 0).
  - Count <= min(Count+1, 8). Count saturates at 8; Full stays high once reached.
  - When Full, the write overwrites the oldest entry; Count is unchanged.
- No write (WrEn=0, Clear=0): all state holds.
- Clear=1 at a rising edge:
  - Same state as reset, applied synchronously.
  - Clear has priority over a simultaneous WrEn; the write is dropped.
- Best/BestIdx:
  - Registered. Computed from the next-state entries and valid mask, so after the edge that performs a write, Best already includes that write.
  - Latency: 0 cycles beyond the write edge.
  - Ties resolve to the lowest slot index.
  - Invalid slots never participate.
  - Overwriting the current best slot with a larger value moves Best to the next minimum on the same edge.
  - With no valid entries: Best = EMPTY_BEST, BestIdx = 0.
- WrData of 0 and of 13'h1FFF are ordinary valid values. A stored 13'h1FFF is reported as Best with its true index.
- Arithmetic: unsigned 13-bit comparison only; no overflow paths. Count is 4 bits so the value 8 is representable.
- Reset asserted mid-sequence discards all history; the first write after release lands in slot 0.
- Outputs are purely registered. No combinational path from WrEn/WrData to W0..W7, Best or Count.

Decomposition:
- Shared package holds:
  - WIDTH and DEPTH.
  - EMPTY_BEST.
  - PTR_W = 3 and CNT_W = 4.
  - A typedef for a 13-bit reaction-time word, shared with the 8:1 selector and the display path.
- One sub-module: min_finder8.
  - Combinational 3-level comparator tree.
  - Inputs: eight words plus an 8-bit valid mask.
  - Outputs: min value and index, lowest index on tie, EMPTY_BEST/0 when the mask is empty.
  - The bank instantiates it on next-state values.

Test Plan:
- Reset, then 3 writes of 500, 320, 410 -> W0=500, W1=320, W2=410, Count=3, WrPtr=3, Full=0, Best=320, BestIdx=1.
- 8 writes of 100..800 step 100, then one write of 50 -> W0=50, WrPtr=1, Count=8, Full=1, Best=50, BestIdx=0.
- Fill with 900 in all slots except slot 3=200, then write so that slot 3 is overwritten with 950 -> Best moves to 900, BestIdx=lowest index holding 900, on the same edge.
- Writes 300, 300 -> Best=300, BestIdx=0 (tie to lowest index); Clear together with WrEn of 10 -> next cycle Count=0, Best=13'h1FFF, W0..W7=0, and 10 is not stored.
- Async Reset pulsed between clock edges after 5 writes -> outputs return to reset values before the next edge; next write of 777 lands in W0, Count=1, Best=777.
- WrEn held high for 20 cycles with an incrementing WrData starting at 1 -> WrPtr wraps twice, Count stays at 8, W0..W7 hold the last 8 values, Best = smallest of those 8.

Source files
------------

// File: rtl/reaction_history_regfile_pkg.sv
// Shared types and constants for the reaction-time history bank, selector and display path.
package reaction_history_regfile_pkg;

  localparam int WIDTH = 13;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int CNT_W = 4;
  localparam logic [WIDTH-1:0] EMPTY_BEST = 13'h1FFF;

  typedef logic [WIDTH-1:0] rt_word_t;

  typedef struct packed {
    logic             vld;
    rt_word_t         val;
    logic [PTR_W-1:0] idx;
  } min_cand_t;

  // a is always the lower-index candidate, so "<=" keeps ties on the lowest slot
  function automatic min_cand_t pick_min(input min_cand_t a, input min_cand_t b);
    pick_min = (a.vld && (!b.vld || a.val <= b.val)) ? a : b;
  endfunction

endpackage

// File: rtl/reaction_history_regfile_min_finder8.sv
// Combinational minimum over eight masked words; lowest index wins ties, EMPTY_BEST/0 when none valid.
module min_finder8
  import reaction_history_regfile_pkg::*;
(
  input  logic [DEPTH-1:0][WIDTH-1:0] words,
  input  logic [DEPTH-1:0]            valid,
  output logic [WIDTH-1:0]            min_val,
  output logic [PTR_W-1:0]            min_idx
);

  min_cand_t lvl0 [DEPTH];
  min_cand_t lvl1 [DEPTH/2];
  min_cand_t lvl2 [DEPTH/4];
  min_cand_t root;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      lvl0[i].vld = valid[i];
      lvl0[i].val = words[i];
      lvl0[i].idx = PTR_W'(i);
    end
    for (int i = 0; i < DEPTH/2; i++) lvl1[i] = pick_min(lvl0[2*i], lvl0[2*i+1]);
    for (int i = 0; i < DEPTH/4; i++) lvl2[i] = pick_min(lvl1[2*i], lvl1[2*i+1]);
    root = pick_min(lvl2[0], lvl2[1]);
  end

  assign min_val = root.vld ? root.val : EMPTY_BEST;
  assign min_idx = root.vld ? root.idx : '0;

endmodule

// File: rtl/reaction_history_regfile.sv
// Eight-slot circular history of reaction times with valid count and registered best (min) tracking.
module reaction_history_regfile
  import reaction_history_regfile_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             WrEn,
  input  logic [WIDTH-1:0] WrData,
  input  logic             Clear,
  output logic [WIDTH-1:0] W0,
  output logic [WIDTH-1:0] W1,
  output logic [WIDTH-1:0] W2,
  output logic [WIDTH-1:0] W3,
  output logic [WIDTH-1:0] W4,
  output logic [WIDTH-1:0] W5,
  output logic [WIDTH-1:0] W6,
  output logic [WIDTH-1:0] W7,
  output logic [PTR_W-1:0] WrPtr,
  output logic [CNT_W-1:0] Count,
  output logic             Full,
  output logic [WIDTH-1:0] Best,
  output logic [PTR_W-1:0] BestIdx
);

  logic [DEPTH-1:0][WIDTH-1:0] entry_q, entry_nxt;
  logic [DEPTH-1:0]            valid_q, valid_nxt;
  logic [PTR_W-1:0]            ptr_q, ptr_nxt;
  logic [CNT_W-1:0]            cnt_q, cnt_nxt;
  logic                        full_q;
  logic [WIDTH-1:0]            best_q, best_nxt;
  logic [PTR_W-1:0]            best_idx_q, best_idx_nxt;

  always_comb begin
    entry_nxt = entry_q;
    valid_nxt = valid_q;
    ptr_nxt   = ptr_q;
    cnt_nxt   = cnt_q;
    if (Clear) begin
      entry_nxt = '0;
      valid_nxt = '0;
      ptr_nxt   = '0;
      cnt_nxt   = '0;
    end else if (WrEn) begin
      entry_nxt[ptr_q] = WrData;
      valid_nxt[ptr_q] = 1'b1;
      ptr_nxt          = ptr_q + PTR_W'(1);
      cnt_nxt          = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // Best is evaluated on next-state contents so it reflects a write on the same edge
  min_finder8 u_min_finder (
    .words   (entry_nxt),
    .valid   (valid_nxt),
    .min_val (best_nxt),
    .min_idx (best_idx_nxt)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      entry_q    <= '0;
      valid_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      best_q     <= EMPTY_BEST;
      best_idx_q <= '0;
    end else begin
      entry_q    <= entry_nxt;
      valid_q    <= valid_nxt;
      ptr_q      <= ptr_nxt;
      cnt_q      <= cnt_nxt;
      full_q     <= (cnt_nxt == CNT_W'(DEPTH));
      best_q     <= best_nxt;
      best_idx_q <= best_idx_nxt;
    end
  end

  assign W0      = entry_q[0];
  assign W1      = entry_q[1];
  assign W2      = entry_q[2];
  assign W3      = entry_q[3];
  assign W4      = entry_q[4];
  assign W5      = entry_q[5];
  assign W6      = entry_q[6];
  assign W7      = entry_q[7];
  assign WrPtr   = ptr_q;
  assign Count   = cnt_q;
  assign Full    = full_q;
  assign Best    = best_q;
  assign BestIdx = best_idx_q;

endmodule
